// File: rtl/mem_io_responder.sv
// mem_io_responder: target side of the CPU byte-wide external memory bus.
// It holds a byte-addressable RAM and an I/O window with these registers:
//   0x30000 write : push a byte to the UART TX FIFO (0x00 is ignored)
//   0x30000 read  : pop the UART RX FIFO (0x00 when the FIFO is empty)
//   0x30004 write : raise program_finished and push a 0x00 end marker to TX
//   0x30004..7 rd : cycle counter, read as a coherent dword (byte 0 first)
// The CPU presents an address on every cycle. A read returns its data on
// mem_din one cycle later.

module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH    = 17,
   parameter int TX_FIFO_DEPTH_BIT = 4,
   parameter int RX_FIFO_DEPTH_BIT = 4,
   parameter int FULL_MARGIN       = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        program_finished,
   output logic        tx_overflow
);

   localparam int TXB      = TX_FIFO_DEPTH_BIT;
   localparam int RXB      = RX_FIFO_DEPTH_BIT;
   localparam int TX_DEPTH = 1 << TXB;
   localparam int RX_DEPTH = 1 << RXB;
   localparam int RAM_SIZE = 1 << RAM_ADDR_WIDTH;

   localparam logic [TXB:0] TX_FULL_CNT   = (TXB+1)'(TX_DEPTH);
   localparam logic [TXB:0] TX_NEAR_LEVEL = (TXB+1)'(TX_DEPTH - FULL_MARGIN);
   localparam logic [RXB:0] RX_FULL_CNT   = (RXB+1)'(RX_DEPTH);

   localparam logic [15:0] IO_UART  = 16'h0000;
   localparam logic [15:0] IO_CNT0  = 16'h0004;
   localparam logic [15:0] IO_CNT1  = 16'h0005;
   localparam logic [15:0] IO_CNT2  = 16'h0006;
   localparam logic [15:0] IO_CNT3  = 16'h0007;

   // Only address bits [17:0] are decoded. The upper bits are accepted and ignored.
   logic [13:0] unusedAddrBits;
   assign unusedAddrBits = mem_a[31:18];

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic                      isIo;
   logic [15:0]               ioOff;
   logic [RAM_ADDR_WIDTH-1:0] ramAddr;
   logic                      ramWe;
   logic                      txPushReq;
   logic [7:0]                txPushData;
   logic                      finishSet;
   logic                      rxPopReq;
   logic                      cntRead;

   // Classify the current bus cycle and work out which side effects it requests.
   always_comb begin
      isIo       = (mem_a[17:16] == 2'b11);
      ioOff      = mem_a[15:0];
      ramAddr    = mem_a[RAM_ADDR_WIDTH-1:0];
      ramWe      = mem_wr && !isIo;
      finishSet  = isIo && mem_wr && (ioOff == IO_CNT0);
      txPushReq  = (isIo && mem_wr && (ioOff == IO_UART) && (mem_dout != 8'h00))
                   || finishSet;
      txPushData = finishSet ? 8'h00 : mem_dout;
      rxPopReq   = isIo && !mem_wr && (ioOff == IO_UART);
      cntRead    = isIo && !mem_wr && (ioOff == IO_CNT0);
   end

   // ------------------------------------------------------------------
   // RAM
   // ------------------------------------------------------------------
   logic [7:0] ram [RAM_SIZE];
   logic [7:0] ramRd_q;

   // The RAM has a synchronous write and a registered read, with no reset, so it maps onto block RAM.
   always_ff @(posedge clk_in) begin
      if (ramWe) begin
         ram[ramAddr] <= mem_dout;
      end
      ramRd_q <= ram[ramAddr];
   end

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   logic [7:0]     txMem [TX_DEPTH];
   logic [TXB-1:0] txHead_q, txHead_d;
   logic [TXB-1:0] txTail_q, txTail_d;
   logic [TXB:0]   txCount_q, txCount_d;
   logic           txFull;
   logic           txPop;
   logic           txPush;
   logic           txOvfSet;
   logic           txNearFull_q, txNearFull_d;
   logic           txOverflow_q, txOverflow_d;

   // A push to a full FIFO is allowed only if the head leaves on the same edge. Otherwise the push is dropped and counted as an overflow.
   always_comb begin
      txFull       = (txCount_q == TX_FULL_CNT);
      txPop        = (txCount_q != '0) && tx_ready;
      txPush       = txPushReq && (!txFull || txPop);
      txOvfSet     = txPushReq && txFull && !txPop;
      txHead_d     = txHead_q + TXB'(txPop);
      txTail_d     = txTail_q + TXB'(txPush);
      txCount_d    = txCount_q;
      if (txPush && !txPop) begin
         txCount_d = txCount_q + 1'b1;
      end else if (txPop && !txPush) begin
         txCount_d = txCount_q - 1'b1;
      end
      txNearFull_d = (txCount_d >= TX_NEAR_LEVEL);
      txOverflow_d = txOverflow_q || txOvfSet;
   end

   // The TX storage has no reset. The reset pointers and count hide any stale entries.
   always_ff @(posedge clk_in) begin
      if (txPush) begin
         txMem[txTail_q] <= txPushData;
      end
   end

   // ------------------------------------------------------------------
   // RX FIFO
   // ------------------------------------------------------------------
   logic [7:0]     rxMem [RX_DEPTH];
   logic [RXB-1:0] rxHead_q, rxHead_d;
   logic [RXB-1:0] rxTail_q, rxTail_d;
   logic [RXB:0]   rxCount_q, rxCount_d;
   logic           rxEmpty;
   logic           rxFull;
   logic           rxPop;
   logic           rxPush;

   // Reading an empty RX FIFO never pops. A byte that arrives on the same cycle stays in the FIFO for the next read.
   always_comb begin
      rxEmpty   = (rxCount_q == '0);
      rxFull    = (rxCount_q == RX_FULL_CNT);
      rxPop     = rxPopReq && !rxEmpty;
      rxPush    = rx_valid && !rxFull;
      rxHead_d  = rxHead_q + RXB'(rxPop);
      rxTail_d  = rxTail_q + RXB'(rxPush);
      rxCount_d = rxCount_q;
      if (rxPush && !rxPop) begin
         rxCount_d = rxCount_q + 1'b1;
      end else if (rxPop && !rxPush) begin
         rxCount_d = rxCount_q - 1'b1;
      end
   end

   // The RX storage has no reset, for the same reason as the TX storage.
   always_ff @(posedge clk_in) begin
      if (rxPush) begin
         rxMem[rxTail_q] <= rx_data;
      end
   end

   // ------------------------------------------------------------------
   // Cycle counter, snapshot and I/O read data
   // ------------------------------------------------------------------
   logic [31:0] cnt_q, cnt_d;
   logic [23:0] snap_q, snap_d;
   logic [7:0]  ioRd_q, ioRd_d;
   logic        rdSelRam_q, rdSelRam_d;
   logic        finished_q, finished_d;

   // Reading byte 0 of the counter latches the upper three bytes. The following byte reads then return one coherent dword.
   always_comb begin
      cnt_d      = cnt_q + 32'd1;
      snap_d     = cntRead ? cnt_q[31:8] : snap_q;
      rdSelRam_d = !isIo && !mem_wr;
      finished_d = finished_q || finishSet;
      ioRd_d     = 8'h00;
      if (isIo && !mem_wr) begin
         case (ioOff)
            IO_UART: ioRd_d = rxEmpty ? 8'h00 : rxMem[rxHead_q];
            IO_CNT0: ioRd_d = cnt_q[7:0];
            IO_CNT1: ioRd_d = snap_q[7:0];
            IO_CNT2: ioRd_d = snap_q[15:8];
            IO_CNT3: ioRd_d = snap_q[23:16];
            default: ioRd_d = 8'h00;
         endcase
      end
   end

   // These are the control state registers. Asserting reset clears every FIFO and every sticky flag at once.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         txHead_q     <= '0;
         txTail_q     <= '0;
         txCount_q    <= '0;
         txNearFull_q <= 1'b0;
         txOverflow_q <= 1'b0;
         rxHead_q     <= '0;
         rxTail_q     <= '0;
         rxCount_q    <= '0;
         cnt_q        <= '0;
         snap_q       <= '0;
         ioRd_q       <= '0;
         rdSelRam_q   <= 1'b0;
         finished_q   <= 1'b0;
      end else begin
         txHead_q     <= txHead_d;
         txTail_q     <= txTail_d;
         txCount_q    <= txCount_d;
         txNearFull_q <= txNearFull_d;
         txOverflow_q <= txOverflow_d;
         rxHead_q     <= rxHead_d;
         rxTail_q     <= rxTail_d;
         rxCount_q    <= rxCount_d;
         cnt_q        <= cnt_d;
         snap_q       <= snap_d;
         ioRd_q       <= ioRd_d;
         rdSelRam_q   <= rdSelRam_d;
         finished_q   <= finished_d;
      end
   end

   // The output read mux chooses the registered RAM byte or the registered I/O byte. tx_data is forced to zero while the TX FIFO is empty, so no stale storage appears on it.
   always_comb begin
      mem_din          = rdSelRam_q ? ramRd_q : ioRd_q;
      tx_valid         = (txCount_q != '0);
      tx_data          = tx_valid ? txMem[txHead_q] : 8'h00;
      io_buffer_full   = txNearFull_q;
      tx_overflow      = txOverflow_q;
      program_finished = finished_q;
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed, self-checking bench for mem_io_responder.
// A vector table covers plain RAM and I/O decode. Hand-written sequences cover
// the TX FIFO, the RX FIFO, the cycle counter, program stop and reset.

module tb_mem_io_responder;

   logic        clk;
   logic        rstN;
   logic [31:0] memA;
   logic        memWr;
   logic [7:0]  memDout;
   logic [7:0]  memDin;
   logic        ioBufferFull;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        programFinished;
   logic        txOverflow;

   int total = 0;
   int bad   = 0;

   logic [7:0] txLog [$];
   logic       logEn = 1'b0;

   mem_io_responder dut (
      .clk_in           (clk),
      .rst_in           (rstN),
      .mem_a            (memA),
      .mem_wr           (memWr),
      .mem_dout         (memDout),
      .mem_din          (memDin),
      .io_buffer_full   (ioBufferFull),
      .tx_data          (txData),
      .tx_valid         (txValid),
      .tx_ready         (txReady),
      .rx_data          (rxData),
      .rx_valid         (rxValid),
      .program_finished (programFinished),
      .tx_overflow      (txOverflow)
   );

   // The free-running clock has a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // This monitor records each byte the UART accepts. Sampling on the falling edge is well away from the edge where the pop happens.
   always @(negedge clk) begin
      if (logEn && txValid && txReady) begin
         txLog.push_back(txData);
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [7:0]  dout;
      logic        chk;
      logic [7:0]  expDin;
   } vec_t;

   vec_t vecs [12];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // applyStimulus drives one bus cycle and returns 1 ns after the sampling edge.
   task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      memA    = a;
      memWr   = wr;
      memDout = d;
      @(posedge clk);
      #1;
      memA    = 32'h0;
      memWr   = 1'b0;
      memDout = 8'h00;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " mem_din"},          {24'h0, memDin}, 32'h0);
      checkOutput({tag, " io_buffer_full"},   {31'h0, ioBufferFull}, 32'h0);
      checkOutput({tag, " tx_data"},          {24'h0, txData}, 32'h0);
      checkOutput({tag, " tx_valid"},         {31'h0, txValid}, 32'h0);
      checkOutput({tag, " program_finished"}, {31'h0, programFinished}, 32'h0);
      checkOutput({tag, " tx_overflow"},      {31'h0, txOverflow}, 32'h0);
   endtask

   task automatic doReset();
      rstN = 1'b0;
      #1;
      checkAllZero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   logic [31:0] dword;
   logic [31:0] logAct;

   initial begin
      memA    = 32'h0;
      memWr   = 1'b0;
      memDout = 8'h00;
      txReady = 1'b0;
      rxData  = 8'h00;
      rxValid = 1'b0;
      rstN    = 1'b0;

      vecs[0]  = '{32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00};
      vecs[1]  = '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5};
      vecs[2]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00};
      vecs[3]  = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C};
      vecs[4]  = '{32'h0000_0000, 1'b1, 8'h55, 1'b0, 8'h00};
      vecs[5]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h55};
      vecs[6]  = '{32'h0003_0010, 1'b0, 8'h00, 1'b1, 8'h00};
      vecs[7]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00};
      vecs[8]  = '{32'h0003_0008, 1'b1, 8'h77, 1'b0, 8'h00};
      vecs[9]  = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00};
      vecs[10] = '{32'hFFFC_0010, 1'b0, 8'h00, 1'b1, 8'hA5};
      vecs[11] = '{32'h0000_0011, 1'b0, 8'h00, 1'b0, 8'h00};

      doReset();

      // Vector table: RAM round trips and I/O decode.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].dout);
         if (vecs[i].chk) begin
            checkOutput($sformatf("vec%0d mem_din", i), {24'h0, memDin}, {24'h0, vecs[i].expDin});
         end
         checkOutput($sformatf("vec%0d tx_valid", i), {31'h0, txValid}, 32'h0);
      end

      // TX path: the 0x00 byte is swallowed, and only 0x41 and 0x42 reach the UART.
      txReady = 1'b1;
      txLog.delete();
      logEn = 1'b1;
      applyStimulus(32'h0003_0000, 1'b1, 8'h41);
      applyStimulus(32'h0003_0000, 1'b1, 8'h00);
      checkOutput("tx zero not pushed", {31'h0, txValid}, 32'h0);
      applyStimulus(32'h0003_0000, 1'b1, 8'h42);
      repeat (3) applyStimulus(32'h0, 1'b0, 8'h00);
      checkOutput("tx burst count", txLog.size(), 32'd2);
      logAct = (txLog.size() > 0) ? {24'h0, txLog[0]} : 32'hFFFF_FFFF;
      checkOutput("tx burst byte0", logAct, 32'h41);
      logAct = (txLog.size() > 1) ? {24'h0, txLog[1]} : 32'hFFFF_FFFF;
      checkOutput("tx burst byte1", logAct, 32'h42);
      logEn = 1'b0;

      // TX fill: near-full at 14 entries, full at 16, and the 17th push overflows.
      txReady = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(32'h0003_0000, 1'b1, 8'(i));
         if (i == 13) checkOutput("ibf after 13", {31'h0, ioBufferFull}, 32'h0);
         if (i == 14) checkOutput("ibf after 14", {31'h0, ioBufferFull}, 32'h1);
         if (i == 16) checkOutput("ovf after 16", {31'h0, txOverflow}, 32'h0);
         if (i == 17) checkOutput("ovf after 17", {31'h0, txOverflow}, 32'h1);
      end
      checkOutput("tx head when full", {24'h0, txData}, 32'h01);
      txLog.delete();
      logEn   = 1'b1;
      txReady = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(32'h0, 1'b0, 8'h00);
         checkOutput($sformatf("ibf drain %0d", k), {31'h0, ioBufferFull},
                     ((16 - k) >= 14) ? 32'h1 : 32'h0);
      end
      checkOutput("tx empty after drain", {31'h0, txValid}, 32'h0);
      checkOutput("drain count", txLog.size(), 32'd16);
      for (int j = 0; j < 16; j++) begin
         logAct = (j < txLog.size()) ? {24'h0, txLog[j]} : 32'hFFFF_FFFF;
         checkOutput($sformatf("drain byte%0d", j), logAct, 32'(j + 1));
      end
      checkOutput("ovf sticky", {31'h0, txOverflow}, 32'h1);
      logEn   = 1'b0;
      txReady = 1'b0;

      // Counter: after 300 edges out of reset, the dword reads 0x12C.
      doReset();
      repeat (300) @(posedge clk);
      #1;
      applyStimulus(32'h0003_0004, 1'b0, 8'h00);
      dword[7:0] = memDin;
      checkOutput("cnt byte0", {24'h0, memDin}, 32'h2C);
      applyStimulus(32'h0003_0005, 1'b0, 8'h00);
      dword[15:8] = memDin;
      applyStimulus(32'h0003_0006, 1'b0, 8'h00);
      dword[23:16] = memDin;
      applyStimulus(32'h0003_0007, 1'b0, 8'h00);
      dword[31:24] = memDin;
      checkOutput("cnt dword", dword, 32'h0000_012C);

      // RX: two bytes arrive, then three reads return 0x31, 0x32 and 0x00.
      rxData  = 8'h31;
      rxValid = 1'b1;
      applyStimulus(32'h0, 1'b0, 8'h00);
      rxData  = 8'h32;
      applyStimulus(32'h0, 1'b0, 8'h00);
      rxValid = 1'b0;
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);
      checkOutput("rx read0", {24'h0, memDin}, 32'h31);
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);
      checkOutput("rx read1", {24'h0, memDin}, 32'h32);
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);
      checkOutput("rx read2 empty", {24'h0, memDin}, 32'h00);
      // A read of the empty RX FIFO on the same cycle as a push returns 0x00 and keeps the pushed byte.
      rxData  = 8'h55;
      rxValid = 1'b1;
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);
      rxValid = 1'b0;
      checkOutput("rx simul empty", {24'h0, memDin}, 32'h00);
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);
      checkOutput("rx simul kept", {24'h0, memDin}, 32'h55);

      // Program stop pushes a 0x00 marker. Reset during the drain clears everything.
      applyStimulus(32'h0003_0004, 1'b1, 8'hAB);
      checkOutput("pf set", {31'h0, programFinished}, 32'h1);
      checkOutput("pf tx_valid", {31'h0, txValid}, 32'h1);
      checkOutput("pf tx_data", {24'h0, txData}, 32'h00);
      applyStimulus(32'h0, 1'b0, 8'h00);
      applyStimulus(32'h0, 1'b0, 8'h00);
      checkOutput("pf sticky", {31'h0, programFinished}, 32'h1);
      applyStimulus(32'h0003_0000, 1'b1, 8'h61);
      applyStimulus(32'h0003_0000, 1'b1, 8'h62);
      applyStimulus(32'h0003_0000, 1'b1, 8'h63);
      txLog.delete();
      logEn   = 1'b1;
      txReady = 1'b1;
      applyStimulus(32'h0, 1'b0, 8'h00);
      applyStimulus(32'h0, 1'b0, 8'h00);
      #2;
      rstN = 1'b0;
      #1;
      checkAllZero("mid-drain reset");
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(32'h0, 1'b0, 8'h00);
      applyStimulus(32'h0, 1'b0, 8'h00);
      checkOutput("fifo empty after reset", {31'h0, txValid}, 32'h0);
      checkOutput("pf cleared", {31'h0, programFinished}, 32'h0);
      checkOutput("drain log count", txLog.size(), 32'd2);
      logAct = (txLog.size() > 0) ? {24'h0, txLog[0]} : 32'hFFFF_FFFF;
      checkOutput("stop marker emitted", logAct, 32'h00);
      logAct = (txLog.size() > 1) ? {24'h0, txLog[1]} : 32'hFFFF_FFFF;
      checkOutput("drain byte after marker", logAct, 32'h61);
      logEn = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target side of the CPU external memory bus. Serves the byte-wide mem_a/mem_wr/mem_dout/mem_din interface that the CPU drives.
- Contains a 128KB byte-addressable RAM and the memory-mapped I/O window: UART TX FIFO, UART RX FIFO, cycle counter and program-stop register.
- Sits between the CPU top and the UART/host link in the FPGA wrapper and in simulation.

Parameters:
- RAM_ADDR_WIDTH, 17, RAM byte address bits (128KB).
- TX_FIFO_DEPTH_BIT, 4, log2 of TX FIFO entries (16).
- RX_FIFO_DEPTH_BIT, 4, log2 of RX FIFO entries (16).
- FULL_MARGIN, 2, free TX slots remaining when io_buffer_full asserts.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- mem_a  input  32  byte address from CPU; only [17:0] decoded
- mem_wr  input  1  1 = write, 0 = read
- mem_dout  input  8  write data from CPU
- mem_din  output  8  read data to CPU
- io_buffer_full  output  1  TX FIFO near full; CPU must not issue 0x30000 writes while high
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  TX FIFO non-empty
- tx_ready  input  1  UART accepts tx_data this cycle
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  rx_data valid; pushed to RX FIFO this cycle
- program_finished  output  1  sticky; set on write to 0x30004
- tx_overflow  output  1  sticky; TX push attempted while FIFO full

Behaviour:
- Reset (rst_in low, async): all outputs 0 (mem_din, io_buffer_full, tx_data, tx_valid, program_finished, tx_overflow). FIFOs emptied, cycle counter 0. RAM contents are not reset. Reset mid-transfer discards the FIFO contents.
- Decode: io = (mem_a[17:16]==2'b11); RAM otherwise, indexed by mem_a[RAM_ADDR_WIDTH-1:0].
- Every cycle is a bus cycle, so side effects occur on each cycle the address is presented. The CPU parks mem_a at 0 with mem_wr=0 when idle.
- RAM write: mem_wr=1 and !io -> RAM[addr] <= mem_dout on the same edge. No response.
- RAM read: mem_wr=0 and !io -> mem_din = RAM[addr] registered, valid exactly 1 cycle after the address. Read-after-write to the same address in back-to-back cycles returns the new data.
- I/O write 0x30000: push mem_dout to TX FIFO; data 0x00 is ignored.
- I/O write 0x30004: set program_finished and push 0x00 to TX FIFO.
- I/O read 0x30000: pop RX FIFO; next-cycle mem_din = popped byte, or 0x00 if the FIFO is empty (no pop).
- Cycle counter: 32-bit, increments every cycle out of reset and wraps at 2^32.
- I/O read 0x30004: mem_din = counter[7:0] next cycle, and counter[31:8] is snapshotted. Reads of 0x30005/6/7 return snapshot bytes 1/2/3, so the dword is coherent.
- Other I/O addresses: reads return 0, writes have no effect.
- TX FIFO:
  - Circular buffer with count; head pops when tx_valid && tx_ready. tx_data = head entry (combinational from storage).
  - A push and pop in the same cycle keeps count constant; allowed when full.
  - A push while full and not popping is dropped and sets tx_overflow.
- io_buffer_full is registered: 1 when count (after this cycle's update) >= 2^TX_FIFO_DEPTH_BIT - FULL_MARGIN. The margin absorbs one cycle of CPU reaction.
- RX FIFO:
  - Push on rx_valid; a push while full is dropped.
  - A simultaneous push and pop is allowed; an empty FIFO with simultaneous push and pop returns 0x00 and keeps the pushed byte.
- Pointers wrap modulo depth; count has one extra bit to distinguish full from empty.

Test Plan:
- Reset release, write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din==0xA5 one cycle after the read address; 0x1FFFF round-trips 0x3C.
- Write 0x41,0x00,0x42 to 0x30000 with tx_ready=1 -> tx_valid bursts deliver 0x41 then 0x42 only; 0x00 is never emitted.
- tx_ready=0, push 14 bytes -> io_buffer_full=1 after the 14th push; push 3 more -> count 16, tx_overflow=1; release tx_ready -> 16 bytes drained in order, io_buffer_full drops once count <14.
- Run 300 cycles, read 0x30004..0x30007 on consecutive cycles -> assembled dword equals the counter value at the 0x30004 read cycle (e.g. 0x0000012C) and is unaffected by later increments.
- rx_valid pulses 0x31,0x32, then read 0x30000 three times -> mem_din 0x31, 0x32, 0x00.
- Write any byte to 0x30004 -> program_finished=1 and stays set, tx emits 0x00. Assert rst_in low mid-drain -> all outputs 0 immediately and FIFOs empty.
